// File: rtl/cmp_trig_pkg.sv
// Shared definitions for the cmp_trig multi-channel threshold trigger.
// Holds the per-channel FSM state type and the default parameter values.
package cmp_trig_pkg;

    localparam int CMP_TRIG_WIDTH = 12;
    localparam int CMP_TRIG_NCH   = 4;
    localparam int CMP_TRIG_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUAL  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_REARM = 2'd3
    } state_t;

endpackage

// File: rtl/cmp_trig_ch.sv
// One trigger channel: registered threshold compare followed by the qualify/holdoff FSM.
// Signed comparison is selected with the CMP_TRIG_SIGNED_EN macro (unsigned by default).
module cmp_trig_ch
    import cmp_trig_pkg::*;
#(
    parameter int P_WIDTH = CMP_TRIG_WIDTH,
    parameter int P_CNT_W = CMP_TRIG_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] sample_i,
    input  logic               valid_i,
    input  logic [P_WIDTH-1:0] thresh_i,
    input  logic               gt_i,
    input  logic               lt_i,
    input  logic               et_i,
    input  logic [P_CNT_W-1:0] min_len_i,
    input  logic [P_CNT_W-1:0] holdoff_i,
    input  logic               arm_i,
    output logic               trig_o,
    output logic               busy_o
);

    logic is_gt;
    logic is_lt;
    logic is_eq;
    logic match_d;
    logic match_q;
    logic match_vld_q;

    always_comb begin
`ifdef CMP_TRIG_SIGNED_EN
        is_gt = $signed(sample_i) > $signed(thresh_i);
        is_lt = $signed(sample_i) < $signed(thresh_i);
`else
        is_gt = sample_i > thresh_i;
        is_lt = sample_i < thresh_i;
`endif
        is_eq   = sample_i == thresh_i;
        match_d = (is_gt && gt_i) || (is_lt && lt_i) || (is_eq && et_i);
    end

    // Stage 1 keeps running regardless of arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q     <= 1'b0;
            match_vld_q <= 1'b0;
        end else begin
            match_q     <= match_d;
            match_vld_q <= valid_i;
        end
    end

    state_t             state_q;
    state_t             state_d;
    logic [P_CNT_W-1:0] cnt_q;
    logic [P_CNT_W-1:0] cnt_d;
    logic               trig_q;
    logic               trig_d;
    logic [P_CNT_W-1:0] eff_min;
    logic [P_CNT_W:0]   cnt_inc;
    logic               fire;

    always_comb begin
        eff_min = (min_len_i == '0) ? P_CNT_W'(1) : min_len_i;
        cnt_inc = {1'b0, cnt_q} + (P_CNT_W + 1)'(1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        fire    = 1'b0;
        if (!arm_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (match_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (match_q) begin
                        if (eff_min <= P_CNT_W'(1)) begin
                            fire = 1'b1;
                        end else begin
                            state_d = ST_QUAL;
                            cnt_d   = P_CNT_W'(1);
                        end
                    end
                end
                ST_QUAL: begin
                    // >= rather than == so a lowered min_len cannot strand the count.
                    if (!match_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= {1'b0, eff_min}) begin
                        fire = 1'b1;
                    end else begin
                        cnt_d = cnt_q + P_CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q <= P_CNT_W'(1)) begin
                        state_d = ST_REARM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - P_CNT_W'(1);
                    end
                end
                ST_REARM: begin
                    if (!match_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            // A zero holdoff skips HOLD entirely.
            if (fire) begin
                trig_d = 1'b1;
                if (holdoff_i == '0) begin
                    state_d = ST_REARM;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = holdoff_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
        end
    end

    assign trig_o = trig_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/cmp_trig.sv
// Multi-channel comparator trigger: P_NCH independent cmp_trig_ch instances.
// Optional macro CMP_TRIG_SIGNED_EN switches all channels to signed comparison.
module cmp_trig
    import cmp_trig_pkg::*;
#(
    parameter int P_WIDTH = CMP_TRIG_WIDTH,
    parameter int P_NCH   = CMP_TRIG_NCH,
    parameter int P_CNT_W = CMP_TRIG_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [P_NCH*P_WIDTH-1:0]   adc_data,
    input  logic                       adc_valid,
    input  logic [P_WIDTH-1:0]         thresh,
    input  logic                       gt,
    input  logic                       lt,
    input  logic                       et,
    input  logic [P_CNT_W-1:0]         min_len,
    input  logic [P_CNT_W-1:0]         holdoff,
    input  logic                       arm,
    output logic [P_NCH-1:0]           trig,
    output logic                       trig_any,
    output logic [P_NCH-1:0]           busy
);

    generate
        for (genvar gi = 0; gi < P_NCH; gi++) begin : g_ch
            cmp_trig_ch #(
                .P_WIDTH (P_WIDTH),
                .P_CNT_W (P_CNT_W)
            ) u_ch (
                .clk       (clk),
                .rst_n     (rst_n),
                .sample_i  (adc_data[gi*P_WIDTH +: P_WIDTH]),
                .valid_i   (adc_valid),
                .thresh_i  (thresh),
                .gt_i      (gt),
                .lt_i      (lt),
                .et_i      (et),
                .min_len_i (min_len),
                .holdoff_i (holdoff),
                .arm_i     (arm),
                .trig_o    (trig[gi]),
                .busy_o    (busy[gi])
            );
        end
    endgenerate

    assign trig_any = |trig;

endmodule

// File: tb/tb_cmp_trig.sv
// Self-checking bench for cmp_trig: vector table driven through a two-deep scoreboard,
// plus hand sequences for reset abort and arm release.
module tb_cmp_trig;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] adc_data;
    logic        adc_valid;
    logic [11:0] thresh;
    logic        gt, lt, et;
    logic [7:0]  min_len, holdoff;
    logic        arm;
    logic [3:0]  trig;
    logic        trig_any;
    logic [3:0]  busy;

    cmp_trig dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .thresh    (thresh),
        .gt        (gt),
        .lt        (lt),
        .et        (et),
        .min_len   (min_len),
        .holdoff   (holdoff),
        .arm       (arm),
        .trig      (trig),
        .trig_any  (trig_any),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] thresh;
        logic        gt, lt, et;
        logic [7:0]  min_len, holdoff;
        logic        arm;
        logic [47:0] data;
        logic        valid;
        logic [3:0]  exp_trig;
        logic [3:0]  exp_busy;
    } vec_t;

    typedef struct {
        logic [3:0] t;
        logic [3:0] b;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [11:0] c_thresh;
    logic        c_gt, c_lt, c_et;
    logic [7:0]  c_min, c_hold;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic logic [47:0] put(input int k, input logic [11:0] val, input logic [47:0] base);
        logic [47:0] r;
        r = base;
        r[k*12 +: 12] = val;
        return r;
    endfunction

    task automatic add_vec(input logic [47:0] d, input logic v, input logic a,
                           input logic [3:0] xt, input logic [3:0] xb);
        vec_t e;
        e.thresh = c_thresh; e.gt = c_gt; e.lt = c_lt; e.et = c_et;
        e.min_len = c_min; e.holdoff = c_hold; e.arm = a;
        e.data = d; e.valid = v; e.exp_trig = xt; e.exp_busy = xb;
        vecs.push_back(e);
    endtask

    // arm=0 on the second entry clears every channel before the next group.
    task automatic add_sep();
        add_vec(48'h0, 1'b0, 1'b1, 4'h0, 4'h0);
        add_vec(48'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic apply(input vec_t v);
        thresh = v.thresh; gt = v.gt; lt = v.lt; et = v.et;
        min_len = v.min_len; holdoff = v.holdoff; arm = v.arm;
        adc_data = v.data; adc_valid = v.valid;
    endtask

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("vec%0d trig", e.idx), {28'h0, trig}, {28'h0, e.t});
        chk($sformatf("vec%0d trig_any", e.idx), {31'h0, trig_any}, {31'h0, |e.t});
        chk($sformatf("vec%0d busy", e.idx), {28'h0, busy}, {28'h0, e.b});
    endtask

    initial begin
        int hits;
        int hit_at;

        // Reset with a matching, valid input present: outputs must stay quiet.
        rst_n = 1'b0; arm = 1'b1; thresh = 12'd100; gt = 1'b1; lt = 1'b0; et = 1'b0;
        min_len = 8'd1; holdoff = 8'd0;
        adc_data = {4{12'd200}}; adc_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset trig", {28'h0, trig}, 32'h0);
        chk("reset trig_any", {31'h0, trig_any}, 32'h0);
        chk("reset busy", {28'h0, busy}, 32'h0);
        adc_valid = 1'b0; adc_data = 48'h0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Group A: three-sample qualification, single pulse on ch0.
        c_thresh = 12'd100; c_gt = 1'b1; c_lt = 1'b0; c_et = 1'b0; c_min = 8'd3; c_hold = 8'd0;
        add_vec(put(0, 12'd101, 48'h0), 1'b1, 1'b1, 4'h0, 4'h1);
        add_vec(put(0, 12'd102, 48'h0), 1'b1, 1'b1, 4'h0, 4'h1);
        add_vec(put(0, 12'd103, 48'h0), 1'b1, 1'b1, 4'h1, 4'h1);
        add_vec(put(0, 12'd104, 48'h0), 1'b1, 1'b1, 4'h0, 4'h1);
        add_sep();
        // Group B: a non-match restarts qualification; a valid gap does not.
        add_vec(put(1, 12'd200, 48'h0), 1'b1, 1'b1, 4'h0, 4'h2);
        add_vec(put(1, 12'd200, 48'h0), 1'b1, 1'b1, 4'h0, 4'h2);
        add_vec(put(1, 12'd50,  48'h0), 1'b1, 1'b1, 4'h0, 4'h0);
        add_vec(put(1, 12'd200, 48'h0), 1'b1, 1'b1, 4'h0, 4'h2);
        add_vec(put(1, 12'd200, 48'h0), 1'b1, 1'b1, 4'h0, 4'h2);
        add_vec(put(1, 12'd200, 48'h0), 1'b0, 1'b1, 4'h0, 4'h2);
        add_vec(put(1, 12'd200, 48'h0), 1'b1, 1'b1, 4'h2, 4'h2);
        add_sep();
        // Group C: holdoff, then no retrigger while held high, rearm on one low sample.
        c_min = 8'd1; c_hold = 8'd4;
        for (int i = 0; i < 20; i++)
            add_vec(put(2, 12'd500, 48'h0), 1'b1, 1'b1, (i == 0) ? 4'h4 : 4'h0, 4'h4);
        add_vec(put(2, 12'd0, 48'h0), 1'b1, 1'b1, 4'h0, 4'h0);
        add_vec(put(2, 12'd500, 48'h0), 1'b1, 1'b1, 4'h4, 4'h4);
        add_sep();
        // Group D: 0x800 against 1 depends on signedness.
        c_thresh = 12'd1; c_hold = 8'd0;
`ifdef CMP_TRIG_SIGNED_EN
        add_vec(put(0, 12'h800, 48'h0), 1'b1, 1'b1, 4'h0, 4'h0);
`else
        add_vec(put(0, 12'h800, 48'h0), 1'b1, 1'b1, 4'h1, 4'h1);
`endif
        add_sep();
        // Group F: less-than match on ch3, equal samples elsewhere must not match.
        c_thresh = 12'd100; c_gt = 1'b0; c_lt = 1'b1; c_min = 8'd2;
        add_vec(put(3, 12'd50, {4{12'd100}}), 1'b1, 1'b1, 4'h0, 4'h8);
        add_vec(put(3, 12'd50, {4{12'd100}}), 1'b1, 1'b1, 4'h8, 4'h8);
        add_sep();
        // Group G: min_len=0 behaves as 1.
        c_gt = 1'b1; c_lt = 1'b0; c_min = 8'd0;
        add_vec(put(0, 12'd200, 48'h0), 1'b1, 1'b1, 4'h1, 4'h1);
        add_vec(put(0, 12'd200, 48'h0), 1'b1, 1'b1, 4'h0, 4'h1);
        add_sep();
        // Group E: all channels fire together on equality.
        c_thresh = 12'h123; c_gt = 1'b0; c_et = 1'b1; c_min = 8'd1; c_hold = 8'd2;
        add_vec({4{12'h123}}, 1'b1, 1'b1, 4'hF, 4'hF);
        add_vec(48'h0, 1'b0, 1'b1, 4'h0, 4'hF);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            sb.push_back('{vecs[i].exp_trig, vecs[i].exp_busy, i});
            @(posedge clk);
            #1;
            if (sb.size() == 2) check_pop();
        end
        adc_valid = 1'b0; arm = 1'b1;
        @(posedge clk);
        #1;
        while (sb.size() > 0) check_pop();

        // Disarm releases every busy channel on the next edge.
        arm = 1'b0;
        @(posedge clk);
        #1;
        chk("disarm busy", {28'h0, busy}, 32'h0);
        chk("disarm trig", {28'h0, trig}, 32'h0);
        arm = 1'b1;

        // Reset during QUAL (cnt=2 of 4) aborts without a pulse.
        thresh = 12'd100; gt = 1'b1; lt = 1'b0; et = 1'b0; min_len = 8'd4; holdoff = 8'd0;
        adc_data = put(0, 12'd200, 48'h0); adc_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        adc_valid = 1'b0;
        @(posedge clk); #1;
        chk("qual busy", {28'h0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst busy async", {28'h0, busy}, 32'h0);
        chk("rst trig async", {28'h0, trig}, 32'h0);
        @(posedge clk); #1;
        chk("rst trig held", {28'h0, trig}, 32'h0);
        rst_n = 1'b1;
        hits = 0; hit_at = -1;
        for (int e = 0; e < 8; e++) begin
            adc_valid = (e < 4);
            @(posedge clk); #1;
            if (trig[0]) begin
                hits++;
                hit_at = e;
            end
        end
        chk("post rst pulses", hits, 1);
        chk("post rst latency", hit_at, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
